// File: rtl/four_12_12_pkg.sv
// four_12_12 shared types: memory request structs, layer sizes
// and the stage-1 read sequencer state encoding.
package four_12_12_pkg;

    localparam int IN_NUM  = 12;
    localparam int OUT_NUM = 12;

    typedef struct packed {
        logic       wr_en;
        logic [4:0] wr_addr;
        logic       rd_en;
        logic [4:0] rd_addr;
    } tap_int_384_5;

    typedef struct packed {
        logic       wr_en;
        logic [8:0] wr_addr;
        logic       rd_en;
        logic [8:0] rd_addr;
    } data_int_32_9;

    typedef struct packed {
        logic       wr_en;
        logic [3:0] wr_addr;
        logic       rd_en;
        logic [3:0] rd_addr;
    } bias_int_32_4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } st1_rd_state_e;

endpackage

// File: rtl/four_12_12_st1_rd_buf.sv
// Two-entry FIFO holding returned stage-1 beats until the MAC takes them.
// Ports: clk, reset (async, active-low), push/push_data, pop, head, count.
module four_12_12_st1_rd_buf
    import four_12_12_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;

    // Push and pop on a full buffer writes the slot being read this
    // cycle; the reader has already consumed it, so this is safe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/four_12_12_st1_mem_rd.sv
// Stage-1 read sequencer: walks OUT_NUM neurons x IN_NUM beats, reads
// tap/data/bias memories and streams the words to the stage-1 MAC.
// Ports: clk, reset (async, active-low), start, data_base, busy, done,
//   tap_int/data_int/bias_int request structs and their rd_data inputs,
//   out_valid/out_ready beat stream with out_tap/data/bias/first/last/idx.
// Option: FOUR_12_12_ST1_MEM_RD_PERF_EN adds stall_cnt [15:0].
module four_12_12_st1_mem_rd
    import four_12_12_pkg::*;
#(
    parameter int TAP_W   = 384,
    parameter int TAP_AW  = 5,
    parameter int DATA_W  = 32,
    parameter int DATA_AW = 9,
    parameter int BIAS_AW = 4,
    parameter int IN_NUM  = four_12_12_pkg::IN_NUM,
    parameter int OUT_NUM = four_12_12_pkg::OUT_NUM,
    parameter int RD_LAT  = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [DATA_AW-1:0] data_base,
    output logic               busy,
    output logic               done,
    output tap_int_384_5       tap_int,
    output data_int_32_9       data_int,
    output bias_int_32_4       bias_int,
    input  logic [TAP_W-1:0]   tap_int_rd_data,
    input  logic [DATA_W-1:0]  data_int_rd_data,
    input  logic [DATA_W-1:0]  bias_int_rd_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [TAP_W-1:0]   out_tap,
    output logic [DATA_W-1:0]  out_data,
    output logic [DATA_W-1:0]  out_bias,
    output logic               out_first,
    output logic               out_last,
    output logic [3:0]         out_idx
`ifdef FOUR_12_12_ST1_MEM_RD_PERF_EN
    ,
    output logic [15:0]        stall_cnt
`endif
);

    localparam int BW = TAP_W + 2 * DATA_W + 6;

    st1_rd_state_e      state_q;
    st1_rd_state_e      state_d;
    logic [3:0]         k_q;
    logic [3:0]         i_q;
    logic [DATA_AW-1:0] base_q;

    // Sideband tags {first, last, idx} ride alongside the memory latency.
    logic [RD_LAT-1:0]  pv_q;
    logic [5:0]         ptag_q [RD_LAT];
    logic [5:0]         issue_tag;
    logic [2:0]         inflight;

    logic               issue;
    logic               last_issue;
    logic               push;
    logic               pop;
    logic [1:0]         cnt;
    logic [BW-1:0]      push_beat;
    logic [BW-1:0]      head;

    always_comb begin
        inflight = '0;
        for (int j = 0; j < RD_LAT; j++) begin
            inflight = inflight + {2'b00, pv_q[j]};
        end
    end

    // Reads in flight plus buffered beats never exceed two, so the
    // buffer cannot overflow however long out_ready stays low.
    assign issue = (state_q == ST_RUN) &&
                   (({1'b0, cnt} + inflight) < 3'd2);

    assign last_issue = issue &&
                        (k_q == 4'(OUT_NUM - 1)) &&
                        (i_q == 4'(IN_NUM - 1));

    assign issue_tag = {(i_q == 4'd0), (i_q == 4'(IN_NUM - 1)), k_q};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            i_q     <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && start) begin
                base_q <= data_base;
                k_q    <= '0;
                i_q    <= '0;
            end else if (issue) begin
                if (i_q == 4'(IN_NUM - 1)) begin
                    i_q <= '0;
                    k_q <= k_q + 4'd1;
                end else begin
                    i_q <= i_q + 4'd1;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (last_issue) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (inflight == 3'd0 && cnt == 2'd0) begin
                    state_d = ST_IDLE;
                    done    = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy = (state_q != ST_IDLE);

    always_comb begin
        tap_int          = '0;
        data_int         = '0;
        bias_int         = '0;
        tap_int.rd_en    = issue;
        data_int.rd_en   = issue;
        bias_int.rd_en   = issue;
        if (issue) begin
            tap_int.rd_addr  = TAP_AW'(k_q);
            bias_int.rd_addr = BIAS_AW'(k_q);
            data_int.rd_addr = base_q + DATA_AW'(i_q);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pv_q <= '0;
            for (int j = 0; j < RD_LAT; j++) begin
                ptag_q[j] <= '0;
            end
        end else begin
            pv_q[0]   <= issue;
            ptag_q[0] <= issue_tag;
            for (int j = 1; j < RD_LAT; j++) begin
                pv_q[j]   <= pv_q[j-1];
                ptag_q[j] <= ptag_q[j-1];
            end
        end
    end

    assign push      = pv_q[RD_LAT-1];
    assign push_beat = {tap_int_rd_data, data_int_rd_data,
                        bias_int_rd_data, ptag_q[RD_LAT-1]};

    four_12_12_st1_rd_buf #(
        .W (BW)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_beat),
        .pop       (pop),
        .head      (head),
        .count     (cnt)
    );

    assign out_valid = (cnt != 2'd0);
    assign pop       = out_valid && out_ready;

    assign {out_tap, out_data, out_bias,
            out_first, out_last, out_idx} = head;

`ifdef FOUR_12_12_ST1_MEM_RD_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (state_q == ST_IDLE && start) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready &&
                     stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_four_12_12_st1_mem_rd.sv
// Bench for the stage-1 read sequencer: random memory contents, a
// beat-order reference queue, backpressure, restart and reset abort.
`timescale 1ns/1ps
module tb_four_12_12_st1_mem_rd;
    import four_12_12_pkg::*;

    localparam int PW = 454;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [8:0]   data_base;
    logic         busy;
    logic         done;
    tap_int_384_5 tap_int;
    data_int_32_9 data_int;
    bias_int_32_4 bias_int;
    logic [383:0] tap_rd;
    logic [31:0]  data_rd;
    logic [31:0]  bias_rd;
    logic         out_valid;
    logic         out_ready;
    logic [383:0] out_tap;
    logic [31:0]  out_data;
    logic [31:0]  out_bias;
    logic         out_first;
    logic         out_last;
    logic [3:0]   out_idx;
`ifdef FOUR_12_12_ST1_MEM_RD_PERF_EN
    logic [15:0]  stall_cnt;
`endif

    logic [383:0] tap_mem [32];
    logic [31:0]  bias_mem [16];
    logic [PW-1:0] exp_q [$];

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    four_12_12_st1_mem_rd dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .data_base        (data_base),
        .busy             (busy),
        .done             (done),
        .tap_int          (tap_int),
        .data_int         (data_int),
        .bias_int         (bias_int),
        .tap_int_rd_data  (tap_rd),
        .data_int_rd_data (data_rd),
        .bias_int_rd_data (bias_rd),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_tap          (out_tap),
        .out_data         (out_data),
        .out_bias         (out_bias),
        .out_first        (out_first),
        .out_last         (out_last),
        .out_idx          (out_idx)
`ifdef FOUR_12_12_ST1_MEM_RD_PERF_EN
        ,
        .stall_cnt        (stall_cnt)
`endif
    );

    // One-cycle-latency memories; the data memory returns its address.
    always @(posedge clk) begin
        if (tap_int.rd_en)  tap_rd  <= tap_mem[tap_int.rd_addr];
        if (data_int.rd_en) data_rd <= 32'(data_int.rd_addr);
        if (bias_int.rd_en) bias_rd <= bias_mem[bias_int.rd_addr];
    end

    task automatic chk(input string tag, input logic [511:0] obs,
                       input logic [511:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] cur();
        return {out_tap, out_data, out_bias, out_first, out_last, out_idx};
    endfunction

    // mode 0: ready=1; 1: random ready + 20-cycle low window;
    // 2: 37 stalled-valid cycles. rst_at>0 aborts at that beat count.
    task automatic run_pass(input logic [8:0] base, input int mode,
                            input int rst_at, input bit restart);
        int cyc = 0, acc = 0, dones = 0, issued = 0;
        int stall_n = 0, win = 0, post = 0;
        bit prev_stall = 0, pulsed = 0, aborted = 0;
        logic rdy;
        logic [PW-1:0] prev = '0;
        logic [PW-1:0] e;
        logic [8:0] a;
        exp_q.delete();
        for (int k = 0; k < OUT_NUM; k++) begin
            for (int i = 0; i < IN_NUM; i++) begin
                a = base + 9'(i);
                exp_q.push_back({tap_mem[k], 23'd0, a, bias_mem[k],
                                 (i == 0), (i == IN_NUM - 1), 4'(k)});
            end
        end
        @(negedge clk);
        data_base = base;
        start     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < 3000 && (dones == 0 || post < 20)) begin
            if (rst_at > 0 && acc == rst_at) begin
                start = 1'b0;
                reset = 1'b0;
                #1;
                chk("rst_valid", out_valid, 0);
                chk("rst_tap_en", tap_int.rd_en, 0);
                chk("rst_data_en", data_int.rd_en, 0);
                chk("rst_bias_en", bias_int.rd_en, 0);
                chk("rst_busy", busy, 0);
                @(negedge clk);
                reset   = 1'b1;
                aborted = 1;
                break;
            end
            rdy = 1'b1;
            if (mode == 1) rdy = 1'($urandom_range(0, 1));
            if (mode == 1 && acc >= 70 && win < 20) begin
                rdy = 1'b0;
                win++;
            end
            if (mode == 2 && acc >= 30 && stall_n < 37) rdy = 1'b0;
            start = restart && acc == 40 && !pulsed;
            if (start) begin
                pulsed    = 1;
                data_base = ~base;
            end
            out_ready = rdy;
            #1;
            if (cyc == 0) chk("busy_run", busy, 1);
            if (prev_stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_hold", cur(), prev);
            end
            if (tap_int.rd_en) begin
                issued++;
                chk("outstanding", (issued - acc) <= 2, 1);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat", cur(), e);
                end
                acc++;
            end
            if (out_valid && !out_ready) stall_n++;
            prev_stall = out_valid && !out_ready;
            prev       = cur();
            if (done) begin
                dones++;
                chk("busy_at_done", busy, 1);
                chk("acc_at_done", acc, 144);
`ifdef FOUR_12_12_ST1_MEM_RD_PERF_EN
                if (mode == 2) chk("stall_cnt", stall_cnt, 37);
`endif
            end
            if (dones > 0) post++;
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
        if (!aborted) begin
            chk("timeout", dones > 0, 1);
            chk("done_once", dones, 1);
            chk("beats", acc, 144);
            chk("busy_end", busy, 0);
            chk("wr_idle", {tap_int.wr_en, data_int.wr_en,
                            bias_int.wr_en}, 0);
        end
    endtask

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        out_ready = 1'b0;
        data_base = '0;
        for (int i = 0; i < 32; i++) begin
            for (int w = 0; w < 12; w++) begin
                tap_mem[i][w*32 +: 32] = $urandom();
            end
        end
        for (int i = 0; i < 16; i++) bias_mem[i] = $urandom();
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy0", busy, 0);
        chk("rst_done0", done, 0);
        chk("rst_valid0", out_valid, 0);
        chk("rst_outs0", cur(), 0);
        chk("rst_tap_req", tap_int, 0);
        chk("rst_data_req", data_int, 0);
        chk("rst_bias_req", bias_int, 0);
        @(negedge clk);
        reset = 1'b1;

        run_pass(9'h000, 0, 0, 0);
        run_pass(9'h1FA, 0, 0, 0);
        run_pass(9'($urandom()), 1, 0, 0);
        run_pass(9'($urandom()), 0, 0, 1);
        run_pass(9'($urandom()), 0, 50, 0);
        run_pass(9'($urandom()), 0, 0, 0);
`ifdef FOUR_12_12_ST1_MEM_RD_PERF_EN
        run_pass(9'($urandom()), 2, 0, 0);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
